// File: rtl/hazard_response_pipe.sv
// hazard_response_pipe: consumer side of the hazard unit in the 5-stage RV32 core.
// Owns pc_IF, IF/ID and ID/EXE, applies operand and store-data forwarding,
// and keeps saturating stall/flush counters for performance debug.
// Ports:
//   clk, rst (sync, active-low)
//   PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush : hazard controls
//   forward_ctrl_A/B (0 rf, 1 alu EXE, 2 alu MEM, 3 load MEM), forward_ctrl_ls
//   next_pc, inst_IF, rs1/rs2_data_ID, rd_ID, alu_res_EXE/MEM, load_data_MEM
//   pc_IF, pc_ID, inst_ID, valid_ID, A_EXE, B_EXE, rd_EXE, valid_EXE
//   store_data_MEM, stall_cnt, flush_cnt
module hazard_response_pipe #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_EN_IF,
  input  logic            reg_FD_stall,
  input  logic            reg_FD_flush,
  input  logic            reg_DE_flush,
  input  logic [1:0]      forward_ctrl_A,
  input  logic [1:0]      forward_ctrl_B,
  input  logic            forward_ctrl_ls,
  input  logic [XLEN-1:0] next_pc,
  input  logic [31:0]     inst_IF,
  input  logic [XLEN-1:0] rs1_data_ID,
  input  logic [XLEN-1:0] rs2_data_ID,
  input  logic [4:0]      rd_ID,
  input  logic [XLEN-1:0] alu_res_EXE,
  input  logic [XLEN-1:0] alu_res_MEM,
  input  logic [XLEN-1:0] load_data_MEM,
  output logic [XLEN-1:0] pc_IF,
  output logic [XLEN-1:0] pc_ID,
  output logic [31:0]     inst_ID,
  output logic            valid_ID,
  output logic [XLEN-1:0] A_EXE,
  output logic [XLEN-1:0] B_EXE,
  output logic [4:0]      rd_EXE,
  output logic            valid_EXE,
  output logic [XLEN-1:0] store_data_MEM,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] store_rs2_q;
  logic [XLEN-1:0] ld_q;
  logic            ls_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_IF <= RESET_PC;
    end else if (PC_EN_IF) begin
      pc_IF <= next_pc;
    end
  end

  // Stall wins over flush; a flush seen during a stall is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_ID    <= '0;
      inst_ID  <= '0;
      valid_ID <= 1'b0;
    end else if (!reg_FD_stall) begin
      if (reg_FD_flush) begin
        pc_ID    <= '0;
        inst_ID  <= NOP;
        valid_ID <= 1'b0;
      end else begin
        pc_ID    <= pc_IF;
        inst_ID  <= inst_IF;
        valid_ID <= 1'b1;
      end
    end
  end

  always_comb begin
    op_a = rs1_data_ID;
    unique case (forward_ctrl_A)
      2'd0: op_a = rs1_data_ID;
      2'd1: op_a = alu_res_EXE;
      2'd2: op_a = alu_res_MEM;
      2'd3: op_a = load_data_MEM;
    endcase
  end

  always_comb begin
    op_b = rs2_data_ID;
    unique case (forward_ctrl_B)
      2'd0: op_b = rs2_data_ID;
      2'd1: op_b = alu_res_EXE;
      2'd2: op_b = alu_res_MEM;
      2'd3: op_b = load_data_MEM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || reg_DE_flush) begin
      A_EXE     <= '0;
      B_EXE     <= '0;
      rd_EXE    <= '0;
      valid_EXE <= 1'b0;
    end else begin
      A_EXE     <= op_a;
      B_EXE     <= op_b;
      rd_EXE    <= rd_ID;
      valid_EXE <= valid_ID;
    end
  end

  // The load feeding a store has reached WB by the time the store
  // is in MEM, so its data is kept one extra cycle in ld_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      store_rs2_q <= '0;
      ls_q        <= 1'b0;
      ld_q        <= '0;
    end else begin
      store_rs2_q <= B_EXE;
      ls_q        <= forward_ctrl_ls & valid_EXE;
      ld_q        <= load_data_MEM;
    end
  end

  assign store_data_MEM = ls_q ? ld_q : store_rs2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (reg_FD_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (reg_FD_flush && !reg_FD_stall &&
          (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
